regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters: port 0 (ALU writeback) and port 1 (load/memory writeback). Each requester uses a valid/ready handshake. One request is granted per cycle, round-robin, and port 1 may lock the port for multi-beat load sequences. The granted write is registered and presented to the register file write port one cycle after acceptance.

## Interface
Parameters:
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, write data width
- LOCK_MAX, 8, maximum consecutive cycles the lock may be held before forced release

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; asynchronous, active-high
- req0_valid_i  in  1  port 0 request valid
- req0_addr_i  in  ADDR_W  port 0 destination register
- req0_data_i  in  DATA_W  port 0 write data
- req0_ready_o  out  1  port 0 accepted this cycle when high with valid
- req1_valid_i  in  1  port 1 request valid
- req1_addr_i  in  ADDR_W  port 1 destination register
- req1_data_i  in  DATA_W  port 1 write data
- req1_lock_i  in  1  port 1 requests to keep ownership after this beat
- req1_ready_o  out  1  port 1 accept
- stall_i  in  1  write port unavailable next cycle; no acceptance this cycle
- wr_en_o  out  1  register file write enable
- wr_addr_o  out  ADDR_W  register file write address
- wr_data_o  out  DATA_W  register file write data
- locked_o  out  1  arbiter in LOCK1 state

## Operation
- Transfer on port k occurs when reqk_valid_i and reqk_ready_o are both high in the same cycle.
- reqk_ready_o = !rst_i & !stall_i & grant_k. The grant is combinational from the state, both valids and rr_ptr. At most one ready is high per cycle.
- State RR grant rules:
  - Only one port valid: that port is granted.
  - Both ports valid: the port indicated by rr_ptr is granted.
  - Neither port valid: no grant.
- rr_ptr: after any transfer from port k, rr_ptr = other port. Reset value 0.
- FSM states are RR and LOCK1. Reset state is RR.
  - RR -> LOCK1: port 1 transfer with req1_lock_i=1.
  - In LOCK1, only port 1 may be granted; req0_ready_o=0.
  - LOCK1 -> RR: port 1 transfer with req1_lock_i=0; rr_ptr becomes 0.
  - LOCK1 -> RR (forced): lock_cnt reaches LOCK_MAX-1. rr_ptr=0. A port 1 transfer in that cycle is still accepted, and its lock request is ignored.
- lock_cnt: clears on entry to LOCK1 and increments each cycle in LOCK1. Width is $clog2(LOCK_MAX)+1.
- Output register on a transfer: next cycle wr_en_o=1 and wr_addr_o/wr_data_o take the accepted values. Otherwise wr_en_o=0 and addr/data hold their last values.
- stall_i high blocks acceptance in that cycle only. It does not change FSM state, rr_ptr, or the already-registered output. lock_cnt keeps counting in LOCK1.

## Timing
- Latency from acceptance to write: 1 cycle. Throughput: 1 write per cycle.
- Reset values: wr_en_o=0, wr_addr_o=0, wr_data_o=0, locked_o=0, readies 0, rr_ptr=0, lock_cnt=0, state RR.
- Reset asserted mid-operation: all outputs clear immediately and the pending write is dropped. On release, port 0 has priority.
- Simultaneous lock exit and port 0 valid: port 0 is granted in the first cycle after exit.
- Back-to-back transfers from the same port are allowed when the other port is idle.

## Configuration
- REGFILE_WB_X0_FILTER_EN defined:
  - A transfer with address 0 is accepted normally and updates FSM state and rr_ptr.
  - The next cycle wr_en_o stays 0, and wr_addr_o/wr_data_o hold their last values.
- REGFILE_WB_X0_FILTER_EN undefined: an address 0 transfer produces wr_en_o=1, wr_addr_o=0. The register file handles x0.

## Structure
- Shared package regfile_pkg holds ADDR_W, DATA_W, LOCK_MAX defaults and the FSM state enum type (RR, LOCK1).
- Sub-module rr_arb2 is natural: two-requester round-robin grant with internal rr_ptr, plus a lock_override input forcing grant to port 1. The FSM, lock counter and output register live in regfile_wb_arbiter.

## Test plan
- After reset, hold both ports valid: port 0 addr 3 data 0xAAAA0001, port 1 addr 5 data 0x55550002. Required: grants alternate 0,1,0,1. wr_en_o high every cycle from cycle 2, with wr_addr_o 3,5,3,5.
- Port 1 sends beats to addr 8, 9, 10 with lock=1,1,0 while port 0 stays valid. Required: req0_ready_o low until the addr 10 beat is accepted; port 0 is accepted the next cycle; locked_o high for 2 cycles.
- Port 1 locks on one beat, then drops valid while port 0 is valid. Required: locked_o falls after 8 cycles in LOCK1; port 0 is accepted in the following cycle.
- stall_i high for 3 cycles with both valid and rr_ptr=1. Required: both readies low and wr_en_o low during the stall (after the registered write drains). Port 1 is granted first after release.
- With REGFILE_WB_X0_FILTER_EN, port 0 sends addr 0 data 0xDEADBEEF. Required: ready high, wr_en_o stays 0, and the following port 1 request is granted. Without the macro: wr_en_o=1, wr_addr_o=0, wr_data_o=0xDEADBEEF.
- Assert rst_i mid-lock with a write pending. Required: wr_en_o, locked_o and readies go 0 without a clock edge. After release, both ports valid gives port 0 first.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and FSM state type for the register-file writeback arbiter.
package regfile_pkg;

    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 32;
    localparam int LOCK_MAX_DEF = 8;

    typedef enum logic {
        RR    = 1'b0,
        LOCK1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with a pointer register and a lock override
// that restricts the grant to requester 1.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic lock_override,
    input  logic xfer0,
    input  logic xfer1,
    input  logic ptr_clear,
    output logic grant0,
    output logic grant1
);

    logic rr_ptr;

    // Pointer names the port that wins the next contended cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (ptr_clear) begin
            rr_ptr <= 1'b0;
        end else if (xfer0) begin
            rr_ptr <= 1'b1;
        end else if (xfer1) begin
            rr_ptr <= 1'b0;
        end
    end

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (lock_override) begin
            grant1 = valid1;
        end else if (valid0 && valid1) begin
            grant0 = !rr_ptr;
            grant1 = rr_ptr;
        end else begin
            grant0 = valid0;
            grant1 = valid1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU (port 0) and load (port 1) writeback.
// Optional REGFILE_WB_X0_FILTER_EN suppresses the write strobe for address-0 transfers.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    input  logic              req1_lock_i,
    output logic              req1_ready_o,
    input  logic              stall_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              locked_o
);

    localparam int LOCK_CNT_W = $clog2(LOCK_MAX) + 1;
    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_MAX - 1);

    arb_state_e            state, state_nxt;
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic                  grant0, grant1;
    logic                  xfer0, xfer1;
    logic                  ptr_clear;
    logic                  lock_expire;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic                  wr_take;

    logic                  wr_en_p1;
    logic [ADDR_W-1:0]     wr_addr_p1;
    logic [DATA_W-1:0]     wr_data_p1;

    rr_arb2 u_rr_arb2 (
        .clk           (clk_i),
        .rst           (rst_i),
        .valid0        (req0_valid_i),
        .valid1        (req1_valid_i),
        .lock_override (state == LOCK1),
        .xfer0         (xfer0),
        .xfer1         (xfer1),
        .ptr_clear     (ptr_clear),
        .grant0        (grant0),
        .grant1        (grant1)
    );

    assign req0_ready_o = !rst_i && !stall_i && grant0;
    assign req1_ready_o = !rst_i && !stall_i && grant1;
    assign xfer0        = req0_valid_i && req0_ready_o;
    assign xfer1        = req1_valid_i && req1_ready_o;
    assign lock_expire  = (state == LOCK1) && (lock_cnt == LOCK_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RR;
        end else begin
            state <= state_nxt;
        end
    end

    // Forced release wins over a lock request on the same beat.
    always_comb begin
        state_nxt = state;
        ptr_clear = 1'b0;
        case (state)
            RR: begin
                if (xfer1 && req1_lock_i) begin
                    state_nxt = LOCK1;
                end
            end
            LOCK1: begin
                if (lock_expire || (xfer1 && !req1_lock_i)) begin
                    state_nxt = RR;
                    ptr_clear = 1'b1;
                end
            end
            default: begin
                state_nxt = RR;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_cnt <= '0;
        end else if (state != LOCK1) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt + 1'b1;
        end
    end

    assign sel_addr = xfer1 ? req1_addr_i : req0_addr_i;
    assign sel_data = xfer1 ? req1_data_i : req0_data_i;

`ifdef REGFILE_WB_X0_FILTER_EN
    assign wr_take = (xfer0 || xfer1) && (sel_addr != '0);
`else
    assign wr_take = xfer0 || xfer1;
`endif

    // Stage p1: accepted write presented to the register file
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_en_p1 <= wr_take;
            if (wr_take) begin
                wr_addr_p1 <= sel_addr;
                wr_data_p1 <= sel_data;
            end
        end
    end

    assign wr_en_o   = wr_en_p1;
    assign wr_addr_o = wr_addr_p1;
    assign wr_data_o = wr_data_p1;
    assign locked_o  = (state == LOCK1);

endmodule
